// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared index type and default widths for the async_fifo write-side arbiter.
package fifo_arb_pkg;
  localparam int MAX_REQ = 16;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 16;
  typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester/FIFO handshake bundle; grant_cnt exists only with FIFO_WR_ARB_STATS_EN.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef FIFO_WR_ARB_STATS_EN
  , parameter int CNT_WIDTH = DEF_CNT_WIDTH
`endif
);
  logic arb_en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0] gnt;
  logic fifo_full;
  logic fifo_overflow;
  logic fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic busy;
  logic ovf_err;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_WIDTH-1:0] grant_cnt;
`endif
  modport master (
    output arb_en, req, req_data, fifo_full, fifo_overflow,
    input gnt, fifo_wr_en, fifo_wdata, busy, ovf_err
`ifdef FIFO_WR_ARB_STATS_EN
    , grant_cnt
`endif
  );
  modport slave (
    input arb_en, req, req_data, fifo_full, fifo_overflow,
    output gnt, fifo_wr_en, fifo_wdata, busy, ovf_err
`ifdef FIFO_WR_ARB_STATS_EN
    , grant_cnt
`endif
  );
endinterface

// File: rtl/fifo_rr_pick.sv
// fifo_rr_pick: combinational round-robin picker, first set req searching upward from last+1 with wrap.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         last,
  output logic [N_REQ-1:0] gnt,
  output req_idx_t         idx
);
  int best;
  // distance of i from last+1 modulo N_REQ; smallest distance wins
  always_comb begin
    best = N_REQ;
    idx = '0;
    gnt = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req[i] && (i + N_REQ - 1 - int'(last)) % N_REQ < best) begin
        best = (i + N_REQ - 1 - int'(last)) % N_REQ;
        idx = req_idx_t'(i);
      end
    for (int i = 0; i < N_REQ; i++) gnt[i] = best < N_REQ && idx == req_idx_t'(i);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter with a one-word output stage feeding async_fifo writes.
// Define FIFO_WR_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input logic wr_clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  logic pend_q, ovf_err_q, free, take;
  logic [DATA_WIDTH-1:0] data_q, sel_data;
  logic [N_REQ-1:0] pick_gnt;
  req_idx_t last_q, pick_idx;
  if (N_REQ < 2 || N_REQ > MAX_REQ || CNT_WIDTH < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: unsupported N_REQ/CNT_WIDTH");
  end
  fifo_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (bus.req),
    .last(last_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );
  // rst masks grant and write so nothing is handed over in a cycle whose state is discarded
  assign free = !pend_q || !bus.fifo_full;
  assign take = !rst && bus.arb_en && free && |bus.req;
  assign bus.gnt = take ? pick_gnt : '0;
  assign bus.fifo_wr_en = pend_q && !bus.fifo_full && !rst;
  assign bus.fifo_wdata = data_q;
  assign bus.busy = pend_q || |bus.req;
  assign bus.ovf_err = ovf_err_q;
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) sel_data |= pick_gnt[i] ? bus.req_data[i] : '0;
  end
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      data_q <= '0;
      last_q <= req_idx_t'(N_REQ - 1);
      ovf_err_q <= 1'b0;
    end else begin
      if (take) begin
        pend_q <= 1'b1;
        data_q <= sel_data;
        last_q <= pick_idx;
      end else if (bus.fifo_wr_en) pend_q <= 1'b0;
      if (bus.fifo_overflow) ovf_err_q <= 1'b1;
    end
  end
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_WIDTH-1:0] cnt_q;
  always_ff @(posedge wr_clk) begin
    if (rst) cnt_q <= '0;
    else
      for (int i = 0; i < N_REQ; i++)
        if (take && pick_gnt[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + 1'b1;
  end
  assign bus.grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scenario tasks plus randomized traffic checked against a queue-based reference model.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef FIFO_WR_ARB_STATS_EN
  localparam int CW = 16;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int m_last = N - 1;
  logic [W-1:0] m_stage[$];
  bit m_ovf = 1'b0;
  int m_cnt[N];
  int left[N];
  int dglog[$];
  logic [W-1:0] dlog[$];
  bit spawn = 1'b0;
  bit inc_mode = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(W)
`ifdef FIFO_WR_ARB_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) b ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(W)
`ifdef FIFO_WR_ARB_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .wr_clk(clk),
    .rst   (rst),
    .bus   (b.slave)
  );

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g = '0;
    if (rst || !b.arb_en || b.req == '0 || (m_stage.size() != 0 && b.fifo_full)) return g;
    for (int k = 1; k <= N; k++) begin
      int j = (m_last + k) % N;
      if (b.req[j]) return N'(1) << j;
    end
    return g;
  endfunction

  function automatic bit exp_wr();
    return m_stage.size() != 0 && !b.fifo_full && !rst;
  endfunction

  // one clock: log DUT handover, advance the model, then let requesters react
  task automatic cyc();
    logic [N-1:0] g;
    bit wr, r;
    g = exp_gnt();
    wr = exp_wr();
    r = rst;
    if (b.fifo_wr_en === 1'b1) dlog.push_back(b.fifo_wdata);
    for (int i = 0; i < N; i++) if (b.gnt[i] === 1'b1) dglog.push_back(i);
    @(posedge clk);
    if (r) begin
      m_stage.delete();
      m_last = N - 1;
      m_ovf = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      if (b.fifo_overflow) m_ovf = 1'b1;
      if (wr) void'(m_stage.pop_front());
      for (int i = 0; i < N; i++)
        if (g[i]) begin
          m_stage.push_back(b.req_data[i]);
          m_last = i;
`ifdef FIFO_WR_ARB_STATS_EN
          if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
`endif
        end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        left[i]--;
        if (left[i] > 0) b.req_data[i] = inc_mode ? W'(b.req_data[i] + 1) : W'($urandom);
        else b.req[i] = 1'b0;
      end else if (spawn && !b.req[i] && $urandom_range(2) == 0) begin
        left[i] = int'($urandom_range(3, 1));
        b.req[i] = 1'b1;
        b.req_data[i] = W'($urandom);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b.req = '0;
    b.arb_en = 1'b1;
    b.fifo_full = 1'b0;
    b.fifo_overflow = 1'b0;
    spawn = 1'b0;
    inc_mode = 1'b0;
    foreach (left[i]) left[i] = 0;
    cyc();
    cyc();
    rst = 1'b0;
    dglog.delete();
    dlog.delete();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b.arb_en = 1'b1;
    b.fifo_full = 1'b0;
    b.fifo_overflow = 1'b0;
    b.req = 4'b0101;
    b.req_data = '0;
    left[0] = 1;
    left[2] = 1;
    cyc();
    cyc();
    #1;
    total++; if (b.gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0", b.gnt); end
    total++; if (b.fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %b want 0", b.fifo_wr_en); end
    total++; if (b.fifo_wdata !== '0) begin bad++; $display("FAIL reset_wdata: got %h want 0", b.fifo_wdata); end
    total++; if (b.ovf_err !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", b.ovf_err); end
    total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL reset_busy_req: got %b want 1", b.busy); end
`ifdef FIFO_WR_ARB_STATS_EN
    total++; if (b.grant_cnt !== '0) begin bad++; $display("FAIL reset_cnt: got %h want 0", b.grant_cnt); end
`endif
    rst = 1'b0;
    #1;
    total++; if (b.gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_gnt: got %b want 0001", b.gnt); end
    cyc();
  endtask

  task automatic test_single();
    do_reset();
    inc_mode = 1'b1;
    left[0] = 8;
    b.req_data[0] = 8'h11;
    b.req[0] = 1'b1;
    #1;
    for (int c = 0; c < 11; c++) begin
      if (c == 0) begin
        total++; if (b.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt0: got %b want 0001", b.gnt); end
      end
      total++;
      if (b.fifo_wr_en !== (c >= 1 && c <= 8)) begin
        bad++; $display("FAIL single_wr_en c=%0d: got %b want %b", c, b.fifo_wr_en, (c >= 1 && c <= 8));
      end
      cyc();
    end
    total++; if (dlog.size() != 8) begin bad++; $display("FAIL single_count: got %0d want 8", dlog.size()); end
    for (int k = 0; k < dlog.size() && k < 8; k++) begin
      total++;
      if (dlog[k] !== W'(8'h11 + k)) begin bad++; $display("FAIL single_word%0d: got %h want %h", k, dlog[k], 8'h11 + k); end
    end
  endtask

  task automatic test_round_robin();
    int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    left = '{2, 2, 1, 1};
    for (int i = 0; i < N; i++) b.req_data[i] = W'($urandom);
    b.req = '1;
    #1;
    for (int c = 0; c < 8; c++) begin
      total++; if (b.gnt !== exp_gnt()) begin bad++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, b.gnt, exp_gnt()); end
      total++; if (!$onehot0(b.gnt)) begin bad++; $display("FAIL rr_onehot c=%0d: got %b want one-hot", c, b.gnt); end
      total++; if (b.fifo_wr_en !== exp_wr()) begin bad++; $display("FAIL rr_wr_en c=%0d: got %b want %b", c, b.fifo_wr_en, exp_wr()); end
      if (exp_wr()) begin
        total++; if (b.fifo_wdata !== m_stage[0]) begin bad++; $display("FAIL rr_wdata c=%0d: got %h want %h", c, b.fifo_wdata, m_stage[0]); end
      end
      cyc();
    end
    total++; if (dglog.size() != 6) begin bad++; $display("FAIL rr_count: got %0d want 6", dglog.size()); end
    for (int k = 0; k < dglog.size() && k < 6; k++) begin
      total++; if (dglog[k] != exp_ord[k]) begin bad++; $display("FAIL rr_order%0d: got %0d want %0d", k, dglog[k], exp_ord[k]); end
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      total++;
      if (b.grant_cnt[i] !== CW'(i < 2 ? 2 : 1)) begin bad++; $display("FAIL rr_cnt%0d: got %0d want %0d", i, b.grant_cnt[i], i < 2 ? 2 : 1); end
    end
`endif
  endtask

  task automatic test_full_stall();
    do_reset();
    left[0] = 1;
    b.req_data[0] = 8'hA5;
    b.req[0] = 1'b1;
    #1;
    cyc();
    b.fifo_full = 1'b1;
    left[1] = 1;
    b.req_data[1] = 8'h3C;
    b.req[1] = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      total++; if (b.fifo_wr_en !== 1'b0) begin bad++; $display("FAIL full_wr_en c=%0d: got %b want 0", c, b.fifo_wr_en); end
      total++; if (b.gnt !== '0) begin bad++; $display("FAIL full_gnt c=%0d: got %b want 0", c, b.gnt); end
      total++; if (b.fifo_wdata !== 8'hA5) begin bad++; $display("FAIL full_hold c=%0d: got %h want a5", c, b.fifo_wdata); end
      cyc();
    end
    b.fifo_full = 1'b0;
    #1;
    total++; if (b.fifo_wr_en !== 1'b1) begin bad++; $display("FAIL full_retry: got %b want 1", b.fifo_wr_en); end
    total++; if (b.fifo_wdata !== 8'hA5) begin bad++; $display("FAIL full_retry_data: got %h want a5", b.fifo_wdata); end
    total++; if (b.gnt !== 4'b0010) begin bad++; $display("FAIL full_refill_gnt: got %b want 0010", b.gnt); end
    cyc();
    total++; if (b.fifo_wr_en !== 1'b1 || b.fifo_wdata !== 8'h3C) begin bad++; $display("FAIL full_next: got %b/%h want 1/3c", b.fifo_wr_en, b.fifo_wdata); end
    total++; if (b.ovf_err !== 1'b0) begin bad++; $display("FAIL full_ovf: got %b want 0", b.ovf_err); end
    cyc();
  endtask

  task automatic test_arb_en();
    logic [W-1:0] g2;
    int k;
    do_reset();
    foreach (left[i]) left[i] = 10;
    for (int i = 0; i < N; i++) b.req_data[i] = W'($urandom);
    b.req = '1;
    g2 = '0;
    k = 0;
    #1;
    while (!(dglog.size() > 0 && dglog[$] == 2) && k < 8) begin
      if (b.gnt[2] === 1'b1) g2 = b.req_data[2];
      cyc();
      k++;
    end
    total++; if (k >= 8) begin bad++; $display("FAIL arb_timeout: got no grant to 2 want grant"); end
    b.arb_en = 1'b0;
    #1;
    total++; if (b.fifo_wr_en !== 1'b1 || b.fifo_wdata !== g2) begin bad++; $display("FAIL arb_drain: got %b/%h want 1/%h", b.fifo_wr_en, b.fifo_wdata, g2); end
    for (int c = 0; c < 4; c++) begin
      total++; if (b.gnt !== '0) begin bad++; $display("FAIL arb_gnt c=%0d: got %b want 0", c, b.gnt); end
      total++; if (b.busy !== 1'b1) begin bad++; $display("FAIL arb_busy c=%0d: got %b want 1", c, b.busy); end
      cyc();
      total++; if (b.fifo_wr_en !== 1'b0) begin bad++; $display("FAIL arb_idle c=%0d: got %b want 0", c, b.fifo_wr_en); end
    end
    b.arb_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    do_reset();
    foreach (left[i]) left[i] = 10;
    b.req = '1;
    #1;
    cyc();
    cyc();
    total++; if (b.fifo_wr_en !== 1'b1) begin bad++; $display("FAIL mrst_pending: got %b want 1", b.fifo_wr_en); end
    rst = 1'b1;
    #1;
    total++; if (b.fifo_wr_en !== 1'b0 || b.gnt !== '0) begin bad++; $display("FAIL mrst_cycle: got %b/%b want 0/0", b.fifo_wr_en, b.gnt); end
    cyc();
    rst = 1'b0;
    #1;
    total++; if (b.fifo_wr_en !== 1'b0) begin bad++; $display("FAIL mrst_wr_en: got %b want 0", b.fifo_wr_en); end
    total++; if (b.ovf_err !== 1'b0) begin bad++; $display("FAIL mrst_ovf: got %b want 0", b.ovf_err); end
    total++; if (b.gnt !== 4'b0001) begin bad++; $display("FAIL mrst_gnt: got %b want 0001", b.gnt); end
    cyc();
  endtask

  task automatic test_overflow();
    do_reset();
    b.fifo_overflow = 1'b1;
    #1;
    cyc();
    b.fifo_overflow = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      total++; if (b.ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky c=%0d: got %b want 1", c, b.ovf_err); end
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    total++; if (b.ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", b.ovf_err); end
  endtask

  task automatic test_random();
    do_reset();
    spawn = 1'b1;
    for (int c = 0; c < 400; c++) begin
      b.fifo_full = $urandom_range(3) == 0;
      b.arb_en = $urandom_range(7) != 0;
      #1;
      total++; if (b.gnt !== exp_gnt()) begin bad++; $display("FAIL rnd_gnt c=%0d: got %b want %b", c, b.gnt, exp_gnt()); end
      total++; if (b.fifo_wr_en !== exp_wr()) begin bad++; $display("FAIL rnd_wr_en c=%0d: got %b want %b", c, b.fifo_wr_en, exp_wr()); end
      if (exp_wr()) begin
        total++; if (b.fifo_wdata !== m_stage[0]) begin bad++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, b.fifo_wdata, m_stage[0]); end
      end
      total++; if (b.busy !== (m_stage.size() != 0 || b.req != '0)) begin bad++; $display("FAIL rnd_busy c=%0d: got %b", c, b.busy); end
      total++; if (b.ovf_err !== m_ovf) begin bad++; $display("FAIL rnd_ovf c=%0d: got %b want %b", c, b.ovf_err, m_ovf); end
      cyc();
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      total++; if (b.grant_cnt[i] !== CW'(m_cnt[i])) begin bad++; $display("FAIL rnd_cnt%0d: got %0d want %0d", i, b.grant_cnt[i], m_cnt[i]); end
    end
`endif
  endtask

  initial begin
    b.arb_en = 1'b0;
    b.req = '0;
    b.req_data = '0;
    b.fifo_full = 1'b0;
    b.fifo_overflow = 1'b0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    foreach (left[i]) left[i] = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_arb_en();
    test_mid_reset();
    test_overflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
